audio_nios_sysid_checker: RTL and testbench

- Boot-time integrity checker that sits directly downstream of the system ID slave.
- Acts as a small Avalon-MM read master: reads the ID word (address 0) and the timestamp word (address 1), each REPEAT times.
- Checks that repeated reads agree, then compares both words against the expected values.
- Exposes sticky done/pass/mismatch status and the captured words, for the HPS/Nios bring-up logic and board LEDs.

---
 rtl/audio_nios_sysid_checker.sv | 204 ++++++++++++++++++++
 tb/tb_audio_nios_sysid_checker.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_nios_sysid_checker.sv
// audio_nios_sysid_checker: boot-time integrity checker for the system ID slave.
// Reads the ID word (address 0) and timestamp word (address 1) REPEAT times each
// over a minimal Avalon-MM read master, flags unstable reads, then compares both
// words against the expected build values and holds a sticky pass/fail summary.
module audio_nios_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1465263482,
    parameter int          READ_LATENCY       = 0,
    parameter int          REPEAT             = 2,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        unstable,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } StateT;

    // Terminal counts: REPEAT is at most 15 and READ_LATENCY at most 3, so
    // 4-bit and 2-bit counters hold every legal value without wrapping.
    localparam int         REP_LAST_I = (REPEAT > 1) ? (REPEAT - 1) : 0;
    localparam logic [3:0] REP_LAST   = REP_LAST_I[3:0];
    localparam int         LAT_LAST_I = (READ_LATENCY > 1) ? (READ_LATENCY - 1) : 0;
    localparam logic [1:0] LAT_LAST   = LAT_LAST_I[1:0];

    StateT       r_state;
    StateT       w_nextState;

    logic        r_autoPending;
    logic        r_address;
    logic [3:0]  r_repCount;
    logic [1:0]  r_latCount;
    logic        r_done;
    logic        r_pass;
    logic        r_idMismatch;
    logic        r_tsMismatch;
    logic        r_unstable;
    logic [31:0] r_idValue;
    logic [31:0] r_tsValue;

    logic        w_startRun;
    logic        w_capture;
    logic        w_enterWait;
    logic        w_latStep;
    logic        w_lastSample;
    logic [31:0] w_storedWord;

    assign w_lastSample = (r_repCount == REP_LAST);
    assign w_storedWord = r_address ? r_tsValue : r_idValue;

    assign sysid_address   = r_address;
    assign sysid_read      = (r_state == ISSUE);
    assign busy            = (r_state == ISSUE) || (r_state == WAIT) || (r_state == CHECK);
    assign done            = r_done;
    assign pass            = r_pass;
    assign id_mismatch     = r_idMismatch;
    assign ts_mismatch     = r_tsMismatch;
    assign unstable        = r_unstable;
    assign id_value        = r_idValue;
    assign timestamp_value = r_tsValue;

    // State register; reset forces IDLE so a run in flight is abandoned at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the per-cycle control strobes that steer the datapath.
    always_comb begin
        w_nextState = r_state;
        w_startRun  = 1'b0;
        w_capture   = 1'b0;
        w_enterWait = 1'b0;
        w_latStep   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start || r_autoPending) begin
                    w_startRun  = 1'b1;
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                if (READ_LATENCY == 0) begin
                    w_capture = 1'b1;
                end else begin
                    w_enterWait = 1'b1;
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (r_latCount == LAT_LAST) begin
                    w_capture = 1'b1;
                end else begin
                    w_latStep = 1'b1;
                end
            end
            CHECK: begin
                w_nextState = DONE;
            end
            DONE: begin
                // The status is published on the way out of DONE, so a start
                // seen here is dropped; a start in the following cycle is taken.
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (w_capture) begin
            if (!w_lastSample || !r_address) begin
                w_nextState = ISSUE;
            end else begin
                w_nextState = CHECK;
            end
        end
    end

    // Datapath: address/repeat/latency counters, captured words and sticky status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_autoPending <= AUTO_START;
            r_address     <= 1'b0;
            r_repCount    <= 4'd0;
            r_latCount    <= 2'd0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_idMismatch  <= 1'b0;
            r_tsMismatch  <= 1'b0;
            r_unstable    <= 1'b0;
            r_idValue     <= 32'd0;
            r_tsValue     <= 32'd0;
        end else begin
            r_autoPending <= 1'b0;

            if (w_startRun) begin
                r_done       <= 1'b0;
                r_pass       <= 1'b0;
                r_idMismatch <= 1'b0;
                r_tsMismatch <= 1'b0;
                r_unstable   <= 1'b0;
                r_repCount   <= 4'd0;
                r_address    <= 1'b0;
            end

            if (w_enterWait) begin
                r_latCount <= 2'd0;
            end else if (w_latStep) begin
                r_latCount <= r_latCount + 2'd1;
            end

            if (w_capture) begin
                if (r_repCount == 4'd0) begin
                    if (r_address) begin
                        r_tsValue <= sysid_readdata;
                    end else begin
                        r_idValue <= sysid_readdata;
                    end
                end else if (sysid_readdata != w_storedWord) begin
                    r_unstable <= 1'b1;
                end

                if (!w_lastSample) begin
                    r_repCount <= r_repCount + 4'd1;
                end else if (!r_address) begin
                    r_address  <= 1'b1;
                    r_repCount <= 4'd0;
                end
            end

            if (r_state == CHECK) begin
                r_idMismatch <= (r_idValue != EXPECTED_ID);
                r_tsMismatch <= (r_tsValue != EXPECTED_TIMESTAMP);
            end

            if (r_state == DONE) begin
                r_done <= 1'b1;
                r_pass <= !(r_idMismatch || r_tsMismatch || r_unstable);
            end
        end
    end

endmodule

// File: tb/tb_audio_nios_sysid_checker.sv
// tb_audio_nios_sysid_checker: two checker instances (zero-latency defaults and a
// 2-cycle pipelined slave with REPEAT=3, no auto start) driven from a vector table
// plus hand-written sequences for start-while-busy, back-to-back and mid-run reset.
module tb_audio_nios_sysid_checker;

    localparam int          LAT_A  = 0;
    localparam int          REP_A  = 2;
    localparam int          LAT_B  = 2;
    localparam int          REP_B  = 3;
    localparam logic [31:0] DEF_TS = 32'd1465263482;
    localparam int          LIMIT  = 200;

    typedef struct {
        int          dut;
        bit          useAuto;
        logic [31:0] idWord;
        logic [31:0] idWord2;
        logic [31:0] tsWord;
        logic        expPass;
        logic        expIdMis;
        logic        expTsMis;
        logic        expUnstable;
        logic [31:0] expIdValue;
        logic [31:0] expTsValue;
    } VecT;

    logic        clock = 1'b0;
    logic [1:0]  rstV;
    logic [1:0]  startV;
    logic [1:0]  addrV;
    logic [1:0]  readV;
    logic [1:0]  busyV;
    logic [1:0]  doneV;
    logic [1:0]  passV;
    logic [1:0]  idmV;
    logic [1:0]  tsmV;
    logic [1:0]  unstV;
    logic [31:0] rdV     [2];
    logic [31:0] idValV  [2];
    logic [31:0] tsValV  [2];
    logic [31:0] idWord  [2];
    logic [31:0] idWord2 [2];
    logic [31:0] tsWord  [2];
    int          idTotal [2] = '{0, 0};
    int          base    [2] = '{0, 0};
    logic [31:0] pipeB1;
    logic [31:0] pipeB2;

    int          vecCount = 0;
    int          errCount = 0;
    logic [31:0] expAddrQA[$];
    logic [31:0] expAddrQB[$];
    VecT         expResQ[$];
    VecT         vecs[$];
    int          cycCnt = 0;
    int          strobeCnt [2] = '{0, 0};
    int          lastStrobeB = 0;
    logic        lastAddrB = 1'b0;
    bit          firstB = 1'b1;

    always #5 clock = ~clock;

    audio_nios_sysid_checker #(
        .READ_LATENCY (LAT_A),
        .REPEAT       (REP_A),
        .AUTO_START   (1'b1)
    ) dutA (
        .clock           (clock),
        .reset_n         (rstV[0]),
        .start           (startV[0]),
        .sysid_address   (addrV[0]),
        .sysid_read      (readV[0]),
        .sysid_readdata  (rdV[0]),
        .busy            (busyV[0]),
        .done            (doneV[0]),
        .pass            (passV[0]),
        .id_mismatch     (idmV[0]),
        .ts_mismatch     (tsmV[0]),
        .unstable        (unstV[0]),
        .id_value        (idValV[0]),
        .timestamp_value (tsValV[0])
    );

    audio_nios_sysid_checker #(
        .READ_LATENCY (LAT_B),
        .REPEAT       (REP_B),
        .AUTO_START   (1'b0)
    ) dutB (
        .clock           (clock),
        .reset_n         (rstV[1]),
        .start           (startV[1]),
        .sysid_address   (addrV[1]),
        .sysid_read      (readV[1]),
        .sysid_readdata  (rdV[1]),
        .busy            (busyV[1]),
        .done            (doneV[1]),
        .pass            (passV[1]),
        .id_mismatch     (idmV[1]),
        .ts_mismatch     (tsmV[1]),
        .unstable        (unstV[1]),
        .id_value        (idValV[1]),
        .timestamp_value (tsValV[1])
    );

    // Zero-latency slave: the first ID read of a run returns idWord, later ones idWord2.
    assign rdV[0] = addrV[0] ? tsWord[0] : ((idTotal[0] == base[0]) ? idWord[0] : idWord2[0]);
    assign rdV[1] = pipeB2;

    // ID read counters for both slaves plus the two-stage pipeline of slave B;
    // non-read cycles feed garbage so a mistimed capture is visible.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (readV[k] && !addrV[k]) idTotal[k] <= idTotal[k] + 1;
        end
        pipeB1 <= readV[1] ? (addrV[1] ? tsWord[1] : ((idTotal[1] == base[1]) ? idWord[1] : idWord2[1]))
                           : 32'hDEADBEEF;
        pipeB2 <= pipeB1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        vecCount++;
        errCount++;
        $display("[TB] FAIL %s: event not expected by scoreboard", name);
    endtask

    // Strobe monitor: every read strobe pops the expected address from the scoreboard.
    always @(negedge clock) begin
        cycCnt = cycCnt + 1;
        if (readV[0]) begin
            strobeCnt[0]++;
            if (expAddrQA.size() == 0) reportFail("dut0.strobeUnexpected");
            else checkOutput("dut0.strobeAddr", 32'(addrV[0]), expAddrQA.pop_front());
        end
        if (readV[1]) begin
            strobeCnt[1]++;
            if (expAddrQB.size() == 0) reportFail("dut1.strobeUnexpected");
            else checkOutput("dut1.strobeAddr", 32'(addrV[1]), expAddrQB.pop_front());
            if (!firstB) checkOutput("dut1.strobeGap", cycCnt - lastStrobeB, 3);
            firstB      = 1'b0;
            lastStrobeB = cycCnt;
            lastAddrB   = addrV[1];
        end else if (busyV[1] && !firstB && (cycCnt - lastStrobeB) <= 2) begin
            checkOutput("dut1.addrHold", 32'(addrV[1]), 32'(lastAddrB));
        end
    end

    function automatic VecT mkVec(input int dut, input bit useAuto, input logic [31:0] id,
                                  input logic [31:0] id2, input logic [31:0] ts, input logic p,
                                  input logic im, input logic tm, input logic un,
                                  input logic [31:0] iv, input logic [31:0] tv);
        VecT v;
        v.dut = dut; v.useAuto = useAuto; v.idWord = id; v.idWord2 = id2; v.tsWord = ts;
        v.expPass = p; v.expIdMis = im; v.expTsMis = tm; v.expUnstable = un;
        v.expIdValue = iv; v.expTsValue = tv;
        return v;
    endfunction

    function automatic int expLat(input int k);
        return (k == 0) ? (2 * REP_A * (1 + LAT_A) + 2) : (2 * REP_B * (1 + LAT_B) + 2);
    endfunction

    task automatic checkResetState(input int k);
        string p = $sformatf("dut%0d.", k);
        checkOutput({p, "resetStatus"}, 32'({busyV[k], doneV[k], passV[k], idmV[k], tsmV[k],
                                              unstV[k], addrV[k], readV[k]}), 32'd0);
        checkOutput({p, "resetIdValue"}, idValV[k], 32'd0);
        checkOutput({p, "resetTsValue"}, tsValV[k], 32'd0);
    endtask

    // Load the slave, queue expected strobes and results, then launch the run.
    task automatic applyStimulus(input VecT v);
        int k   = v.dut;
        int rep = (k == 0) ? REP_A : REP_B;
        idWord[k]  = v.idWord;
        idWord2[k] = v.idWord2;
        tsWord[k]  = v.tsWord;
        base[k]    = idTotal[k];
        for (int a = 0; a < 2; a++) begin
            for (int r = 0; r < rep; r++) begin
                if (k == 0) expAddrQA.push_back(32'(a));
                else expAddrQB.push_back(32'(a));
            end
        end
        expResQ.push_back(v);
        if (k == 1) firstB = 1'b1;
        if (v.useAuto) rstV[k] = 1'b1;
        else startV[k] = 1'b1;
        @(negedge clock);
        startV[k] = 1'b0;
    endtask

    // Bounded wait for done, checking busy every cycle; optionally pokes start at pokeCyc.
    task automatic waitDone(input int k, input int pokeCyc);
        int cyc = 0;
        int lat = expLat(k);
        string p = $sformatf("dut%0d.", k);
        while (doneV[k] !== 1'b1 && cyc < LIMIT) begin
            if (cyc < lat) checkOutput($sformatf("%sbusy@%0d", p, cyc), 32'(busyV[k]), 32'(cyc < lat - 1));
            startV[k] = (cyc == pokeCyc);
            @(negedge clock);
            cyc++;
        end
        startV[k] = 1'b0;
        checkOutput({p, "doneLatency"}, cyc, lat);
        checkOutput({p, "busyAtDone"}, 32'(busyV[k]), 32'd0);
    endtask

    task automatic checkResult(input int k);
        VecT e;
        string p = $sformatf("dut%0d.", k);
        if (expResQ.size() == 0) begin
            reportFail({p, "resultUnexpected"});
        end else begin
            e = expResQ.pop_front();
            checkOutput({p, "done"},       32'(doneV[k]), 32'd1);
            checkOutput({p, "pass"},       32'(passV[k]), 32'(e.expPass));
            checkOutput({p, "idMismatch"}, 32'(idmV[k]),  32'(e.expIdMis));
            checkOutput({p, "tsMismatch"}, 32'(tsmV[k]),  32'(e.expTsMis));
            checkOutput({p, "unstable"},   32'(unstV[k]), 32'(e.expUnstable));
            checkOutput({p, "idValue"},    idValV[k],     e.expIdValue);
            checkOutput({p, "tsValue"},    tsValV[k],     e.expTsValue);
        end
        checkOutput({p, "strobesLeft"}, (k == 0) ? expAddrQA.size() : expAddrQB.size(), 0);
    endtask

    initial begin
        VecT defA;
        int  sc;
        rstV   = 2'b00;
        startV = 2'b00;
        for (int k = 0; k < 2; k++) begin
            idWord[k] = 32'd0; idWord2[k] = 32'd0; tsWord[k] = DEF_TS;
        end

        defA = mkVec(0, 1'b0, 32'd0, 32'd0, DEF_TS, 1, 0, 0, 0, 32'd0, DEF_TS);
        vecs.push_back(mkVec(0, 1'b1, 32'd0, 32'd0, DEF_TS, 1, 0, 0, 0, 32'd0, DEF_TS));
        vecs.push_back(mkVec(0, 1'b0, 32'd0, 32'd0, 32'h57550000, 0, 0, 1, 0, 32'd0, 32'h57550000));
        vecs.push_back(mkVec(0, 1'b0, 32'd0, 32'd1, DEF_TS, 0, 0, 0, 1, 32'd0, DEF_TS));
        vecs.push_back(mkVec(0, 1'b0, 32'hCAFE0001, 32'hCAFE0001, DEF_TS, 0, 1, 0, 0, 32'hCAFE0001, DEF_TS));
        vecs.push_back(mkVec(0, 1'b0, 32'd1, 32'd1, 32'd2, 0, 1, 1, 0, 32'd1, 32'd2));
        vecs.push_back(mkVec(1, 1'b0, 32'd0, 32'd0, DEF_TS, 1, 0, 0, 0, 32'd0, DEF_TS));
        vecs.push_back(mkVec(1, 1'b0, 32'd0, 32'h0000FFFF, DEF_TS, 0, 0, 0, 1, 32'd0, DEF_TS));
        vecs.push_back(mkVec(1, 1'b0, 32'h12345678, 32'h12345678, DEF_TS, 0, 1, 0, 0, 32'h12345678, DEF_TS));

        repeat (3) @(negedge clock);
        checkResetState(0);
        checkResetState(1);

        // Instance B has no auto start: releasing reset must leave it idle.
        rstV[1] = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("dut1.noAutoStart", 32'({busyV[1], doneV[1], readV[1]}), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            waitDone(vecs[i].dut, -1);
            checkResult(vecs[i].dut);
        end

        // Start pulsed mid-run is ignored; start in the done cycle launches a new run.
        $display("[TB] start while busy, then start on done");
        applyStimulus(defA);
        waitDone(0, 2);
        checkResult(0);
        applyStimulus(defA);
        checkOutput("dut0.doneClears", 32'({doneV[0], passV[0], busyV[0]}), 32'b001);
        waitDone(0, -1);
        checkResult(0);

        // Reset during the second ID read aborts the run; auto start re-arms.
        $display("[TB] reset during second ID read");
        applyStimulus(defA);
        @(negedge clock);
        checkOutput("dut0.secondIdRead", 32'({addrV[0], readV[0]}), 32'b01);
        #2 rstV[0] = 1'b0;
        #1 checkResetState(0);
        checkOutput("dut0.abortPending", expAddrQA.size(), 2);
        expAddrQA.delete();
        expResQ.delete();
        sc = strobeCnt[0];
        repeat (3) @(negedge clock);
        checkOutput("dut0.noStrobeInReset", strobeCnt[0], sc);
        checkResetState(0);
        defA.useAuto = 1'b1;
        applyStimulus(defA);
        waitDone(0, -1);
        checkResult(0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
